req_ack_fifo_source: RTL and testbench



---
 rtl/req_ack_fifo_source.sv | 100 ++++++++++
 tb/tb_req_ack_fifo_source.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/req_ack_fifo_source.sv
// FIFO-backed req/ack responder: words pushed on a strobe port are served one per
// completed handshake once every fan-out requester is asserting req.
module req_ack_fifo_source #(
  parameter int data_width  = 32,
  parameter int depth       = 8,
  parameter int output_size = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [data_width-1:0]    push_data,
  output logic                     full,
  output logic                     overflow,
  input  logic [output_size-1:0]   req,
  output logic                     ack,
  output logic [data_width-1:0]    dout,
  output logic [$clog2(depth):0]   level,
  output logic [31:0]              count
);

  localparam int AW = $clog2(depth);
  localparam int LW = AW + 1;

  // state  | meaning
  // IDLE   | ack low, a serve may be issued
  // ACKED  | ack high for exactly one cycle, serving is blocked
  typedef enum logic {IDLE = 1'b0, ACKED = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         wp_q, wp_d;
  logic [AW-1:0]         rp_q, rp_d;
  logic [LW-1:0]         level_q, level_d;
  logic [31:0]           count_q, count_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic                  ovf_q, ovf_d;
  logic                  accept, serve;

  logic [data_width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is deliberately left out of reset; stale entries are never read.
  always_ff @(posedge clk) begin
    if (rst && accept) begin
      mem[wp_q] <= push_data;
    end
  end

  always_comb begin
    accept  = push & ~full;
    serve   = (&req) & (state_q == IDLE) & (level_q != '0);
    state_d = IDLE;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q | (push & full);
    level_d = level_q;
    if (accept) begin
      wp_d = wp_q + AW'(1);
    end
    if (serve) begin
      state_d = ACKED;
      dout_d  = mem[rp_q];
      rp_d    = rp_q + AW'(1);
      count_d = count_q + 32'd1;
    end
    case ({accept, serve})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  assign full     = (level_q == LW'(depth));
  assign overflow = ovf_q;
  assign ack      = (state_q == ACKED);
  assign dout     = dout_q;
  assign level    = level_q;
  assign count    = count_q;

endmodule

// File: tb/tb_req_ack_fifo_source.sv
// Directed bench for req_ack_fifo_source (depth 8, two requesters driven together
// where a standard requester is modelled).
module tb_req_ack_fifo_source;

  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic [31:0] push_data;
  logic        full;
  logic        overflow;
  logic [1:0]  req;
  logic        ack;
  logic [31:0] dout;
  logic [3:0]  level;
  logic [31:0] count;

  int n_tot = 0;
  int n_bad = 0;
  logic [31:0] got[$];
  logic [31:0] sent[$];
  bit hold;

  req_ack_fifo_source #(.data_width(32), .depth(8), .output_size(2)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .full(full),
    .overflow(overflow), .req(req), .ack(ack), .dout(dout), .level(level), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive push, take the edge, log any ack, optionally run the standard requester.
  task automatic cyc(input logic p, input logic [31:0] d, input bit std);
    push = p;
    push_data = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    if (ack) got.push_back(dout);
    if (std) begin
      if (ack) hold = 1'b1;
      else if (hold) begin
        req = 2'b00;
        hold = 1'b0;
      end else req = 2'b11;
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    req = 2'b00;
    push = 1'b0;
    push_data = '0;
    hold = 1'b0;
    got.delete();
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_ack"}, {31'd0, ack}, 32'd0);
    chk({tag, "_dout"}, dout, 32'd0);
    chk({tag, "_count"}, count, 32'd0);
    chk({tag, "_level"}, {28'd0, level}, 32'd0);
    chk({tag, "_full_ovf"}, {30'd0, full, overflow}, 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    bit quiet;
    int guard;

    // basic stream 1,2,3
    do_reset("rst1");
    req = 2'b11;
    cyc(1'b1, 32'd1, 1'b1);
    cyc(1'b1, 32'd2, 1'b1);
    cyc(1'b1, 32'd3, 1'b1);
    repeat (12) cyc(1'b0, 32'd0, 1'b1);
    chk("t1_nacks", got.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t1_word%0d", i), (i < got.size()) ? got[i] : 32'hdead, 32'(i + 1));
    chk("t1_count", count, 32'd3);
    chk("t1_level", {28'd0, level}, 32'd0);

    // fill to full, drop the ninth word, then drain
    do_reset("rst2");
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'(i), 1'b0);
    chk("t2_full8", {31'd0, full}, 32'd1);
    chk("t2_noovf8", {31'd0, overflow}, 32'd0);
    cyc(1'b1, 32'd8, 1'b0);
    chk("t2_ovf", {31'd0, overflow}, 32'd1);
    chk("t2_level", {28'd0, level}, 32'd8);
    repeat (40) cyc(1'b0, 32'd0, 1'b1);
    chk("t2_nacks", got.size(), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2_word%0d", i), (i < got.size()) ? got[i] : 32'hdead, 32'(i));
    chk("t2_ovf_sticky", {31'd0, overflow}, 32'd1);

    // partial request holds the FIFO
    do_reset("rst3");
    req = 2'b01;
    quiet = 1'b1;
    cyc(1'b1, 32'd5, 1'b0);
    if (ack) quiet = 1'b0;
    repeat (9) begin
      cyc(1'b0, 32'd0, 1'b0);
      if (ack) quiet = 1'b0;
    end
    chk("t3_no_ack", {31'd0, quiet}, 32'd1);
    req = 2'b11;
    cyc(1'b0, 32'd0, 1'b0);
    chk("t3_ack", {31'd0, ack}, 32'd1);
    chk("t3_dout", dout, 32'd5);
    cyc(1'b0, 32'd0, 1'b0);
    chk("t3_ack_pulse", {31'd0, ack}, 32'd0);

    // wrap-around with random push gaps
    do_reset("rst4");
    sent.delete();
    guard = 0;
    while (sent.size() < 40 && guard < 2000) begin
      if (!full && $urandom_range(0, 1) == 1) begin
        sent.push_back(32'(100 + sent.size()));
        cyc(1'b1, sent[sent.size() - 1], 1'b1);
      end else cyc(1'b0, 32'd0, 1'b1);
      guard++;
    end
    guard = 0;
    while (got.size() < 40 && guard < 400) begin
      cyc(1'b0, 32'd0, 1'b1);
      guard++;
    end
    chk("t4_nwords", got.size(), 32'd40);
    for (int i = 0; i < 40; i++)
      chk($sformatf("t4_word%0d", i), (i < got.size()) ? got[i] : 32'hdead, 32'(100 + i));
    chk("t4_count", count, 32'd40);
    chk("t4_ovf", {31'd0, overflow}, 32'd0);

    // simultaneous push and serve at level 3
    do_reset("rst5");
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'(20 + i), 1'b0);
    chk("t5_level_pre", {28'd0, level}, 32'd3);
    req = 2'b11;
    cyc(1'b1, 32'd23, 1'b0);
    chk("t5_ack", {31'd0, ack}, 32'd1);
    chk("t5_dout", dout, 32'd20);
    chk("t5_level", {28'd0, level}, 32'd3);

    // reset mid-handshake
    do_reset("rst6");
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'(30 + i), 1'b0);
    req = 2'b11;
    cyc(1'b0, 32'd0, 1'b0);
    chk("t6_ack_pre", {31'd0, ack}, 32'd1);
    chk("t6_level_pre", {28'd0, level}, 32'd4);
    rst = 1'b0;
    cyc(1'b0, 32'd0, 1'b0);
    chk("t6_ack", {31'd0, ack}, 32'd0);
    chk("t6_level", {28'd0, level}, 32'd0);
    chk("t6_count", count, 32'd0);
    rst = 1'b1;
    req = 2'b00;
    hold = 1'b0;
    got.delete();
    cyc(1'b1, 32'd9, 1'b1);
    guard = 0;
    while (got.size() < 1 && guard < 20) begin
      cyc(1'b0, 32'd0, 1'b1);
      guard++;
    end
    chk("t6_new_word", (got.size() > 0) ? got[0] : 32'hdead, 32'd9);
    chk("t6_new_count", count, 32'd1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
